// File: rtl/vram_write_arbiter_if.sv
// Bus bundle between the VRAM write arbiter, the frame drawer, the processor write port
// and the single-port VRAM.
interface vram_write_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 4
);
  logic              i_active;
  logic [ADDR_W-1:0] i_rd_addr;
  logic [DATA_W-1:0] o_rd_data;
  logic              i_wr_valid;
  logic              o_wr_ready;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [DATA_W-1:0] i_wr_data;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic              o_mem_we;
  logic [DATA_W-1:0] i_mem_rdata;
  logic [CNT_W-1:0]  o_fifo_count;

  modport slave (
    input  i_active, i_rd_addr, i_wr_valid, i_wr_addr, i_wr_data, i_mem_rdata,
    output o_rd_data, o_wr_ready, o_mem_addr, o_mem_wdata, o_mem_we, o_fifo_count
  );

  modport master (
    output i_active, i_rd_addr, i_wr_valid, i_wr_addr, i_wr_data, i_mem_rdata,
    input  o_rd_data, o_wr_ready, o_mem_addr, o_mem_wdata, o_mem_we, o_fifo_count
  );
endinterface

// File: rtl/vram_write_arbiter.sv
// Single-port VRAM arbiter: the display read path owns the port during active video,
// queued processor writes drain through a FIFO during blanking.
module vram_write_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  vram_write_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

  localparam logic [0:0] S_READ  = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;

  logic [0:0]       state_r, state_next_s;
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r, count_next_s;
  logic [ENT_W-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [ENT_W-1:0] head_s;
  logic             push_s, pop_s, wr_mode_s, full_s, empty_s;

  assign full_s  = (count_r == FULL_CNT);
  assign empty_s = (count_r == ZERO_CNT);
  assign head_s  = fifo_mem_r[rd_ptr_r];

  // Active video overrides the write state combinationally, so a write never collides with a fetch.
  assign wr_mode_s = (state_r == S_WRITE) && !bus.i_active && !empty_s;
  assign pop_s     = wr_mode_s;
  assign push_s    = bus.i_wr_valid && !full_s;

  assign bus.o_wr_ready   = !full_s;
  assign bus.o_fifo_count = count_r;
  assign bus.o_mem_we     = wr_mode_s;
  assign bus.o_mem_addr   = wr_mode_s ? head_s[ENT_W-1:DATA_W] : bus.i_rd_addr;
  assign bus.o_mem_wdata  = wr_mode_s ? head_s[DATA_W-1:0] : {DATA_W{1'b0}};

  // Occupancy update for push, pop or both.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Port ownership state machine.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_READ: begin
        if (!bus.i_active && !empty_s) state_next_s = S_WRITE;
        else                           state_next_s = S_READ;
      end
      S_WRITE: begin
        if (bus.i_active || (count_next_s == ZERO_CNT)) state_next_s = S_READ;
        else                                            state_next_s = S_WRITE;
      end
      default: state_next_s = S_READ;
    endcase
  end

  // Control state, pointers, occupancy and the registered read data.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r       <= S_READ;
      wr_ptr_r      <= {PTR_W{1'b0}};
      rd_ptr_r      <= {PTR_W{1'b0}};
      count_r       <= ZERO_CNT;
      bus.o_rd_data <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      count_r <= count_next_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      if (!wr_mode_s) bus.o_rd_data <= bus.i_mem_rdata;
    end
  end

  // FIFO storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge i_clk) begin
    if (push_s) fifo_mem_r[wr_ptr_r] <= {bus.i_wr_addr, bus.i_wr_data};
  end
endmodule
